// File: rtl/oled_char_draw_pkg.sv
// Shared constants and types for the OLED 8x16 character renderer.
package oled_char_draw_pkg;

  localparam int unsigned GLYPH_W     = 8;
  localparam int unsigned GLYPH_BYTES = 16;
  localparam logic [7:0]  FIRST_ASCII = 8'h20;
  localparam logic [7:0]  LAST_ASCII  = 8'h7E;
  localparam int unsigned COLS        = 128;
  localparam int unsigned PAGES       = 8;
  localparam int unsigned FONT_DEPTH  = 1520;
  localparam int unsigned FONT_AW     = 11;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWrite,
    StDone
  } draw_state_e;

  // Map unprintable codes onto the substitute glyph.
  function automatic logic [7:0] sub_ascii(input logic [7:0] code, input logic [7:0] sub);
    return ((code < FIRST_ASCII) || (code > LAST_ASCII)) ? sub : code;
  endfunction

endpackage

// File: rtl/oled_font_rom.sv
// Synchronous 1520x8 glyph ROM, one cycle read latency; output only updates when enabled.
// Contents are a generated stand-in pattern until the real font table is dropped in.
module oled_font_rom
  import oled_char_draw_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [FONT_AW-1:0]   i_addr,
  output logic [7:0]           o_data
);

  logic [7:0] w_byte;
  logic [7:0] r_data;

  always_comb begin
    w_byte = 8'h00;
    if (32'(i_addr) < FONT_DEPTH) begin
      w_byte = i_addr[7:0] ^ {1'b0, i_addr[10:4]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= 8'h00;
    end else if (i_en) begin
      r_data <= w_byte;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/oled_char_draw.sv
// Renders one 8x16 glyph as 16 column-byte writes into an external page-organised framebuffer,
// with a single-entry pending slot so back-to-back requests run without an idle gap.
module oled_char_draw
  import oled_char_draw_pkg::*;
#(
  parameter logic [7:0] SUB_ASCII = 8'h20
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       draw_start,
  input  logic [7:0] draw_ascii,
  input  logic [6:0] draw_x,
  input  logic [3:0] draw_y,
  input  logic       ovf_clr,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  draw_state_e r_state, w_state_d;

  logic [4:0]  r_cnt;
  logic [7:0]  r_code;
  logic [6:0]  r_x;
  logic [2:0]  r_y;
  logic        r_pend_vld;
  logic [7:0]  r_pend_code;
  logic [6:0]  r_pend_x;
  logic [2:0]  r_pend_y;
  logic        r_fb_we;
  logic [9:0]  r_fb_addr;
  logic        r_ovf;

  logic        w_req_ok, w_rendering;
  logic        w_load_in, w_start_pend, w_capture, w_drop;
  logic [7:0]  w_in_code;
  logic [3:0]  w_k;
  logic [7:0]  w_col;
  logic [2:0]  w_page;
  logic [6:0]  w_off;
  logic        w_issue, w_byte_ok, w_wr;
  logic [10:0] w_rom_addr;
  logic [7:0]  w_rom_data;

  assign w_req_ok    = draw_start && (draw_y < 4'(PAGES));
  assign w_rendering = (r_state == StFetch) || (r_state == StWrite);
  assign w_in_code   = sub_ascii(draw_ascii, SUB_ASCII);

  // A request seen in the done cycle starts directly if nothing is already queued.
  assign w_load_in    = w_req_ok && ((r_state == StIdle) || ((r_state == StDone) && !r_pend_vld));
  assign w_start_pend = (r_state == StDone) && r_pend_vld;
  assign w_capture    = w_req_ok && ((w_rendering && !r_pend_vld) || w_start_pend);
  assign w_drop       = w_req_ok && w_rendering && r_pend_vld;

  assign w_k        = r_cnt[3:0];
  assign w_col      = {1'b0, r_x} + {5'b0, w_k[2:0]};
  assign w_page     = r_y + {2'b0, w_k[3]};
  assign w_off      = 7'(r_code - FIRST_ASCII);
  assign w_rom_addr = {w_off, w_k};
  assign w_issue    = (r_state == StFetch) || ((r_state == StWrite) && (r_cnt < 5'(GLYPH_BYTES)));
  // Off-screen bytes keep their slot but never write, so timing is placement-independent.
  assign w_byte_ok  = !w_col[7] && !(w_k[3] && (r_y == 3'(PAGES - 1)));
  assign w_wr       = w_issue && w_byte_ok;

  oled_font_rom u_font_rom (
    .i_clk   (clk_50m),
    .i_rst_n (rst_n),
    .i_en    (w_wr),
    .i_addr  (w_rom_addr),
    .o_data  (w_rom_data)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (draw_start) w_state_d = w_req_ok ? StFetch : StDone;
      StFetch: w_state_d = StWrite;
      StWrite: if (r_cnt == 5'(GLYPH_BYTES)) w_state_d = StDone;
      StDone:  w_state_d = (r_pend_vld || w_req_ok) ? StFetch : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 5'd0;
      r_code      <= FIRST_ASCII;
      r_x         <= 7'd0;
      r_y         <= 3'd0;
      r_pend_vld  <= 1'b0;
      r_pend_code <= FIRST_ASCII;
      r_pend_x    <= 7'd0;
      r_pend_y    <= 3'd0;
      r_fb_we     <= 1'b0;
      r_fb_addr   <= 10'd0;
      r_ovf       <= 1'b0;
    end else begin
      r_cnt   <= w_rendering ? r_cnt + 5'd1 : 5'd0;
      r_fb_we <= w_wr;
      if (w_wr) begin
        r_fb_addr <= {w_page, w_col[6:0]};
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_load_in) begin
        r_code <= w_in_code;
        r_x    <= draw_x;
        r_y    <= draw_y[2:0];
      end else if (w_start_pend) begin
        r_code <= r_pend_code;
        r_x    <= r_pend_x;
        r_y    <= r_pend_y;
      end
      if (w_capture) begin
        r_pend_vld  <= 1'b1;
        r_pend_code <= w_in_code;
        r_pend_x    <= draw_x;
        r_pend_y    <= draw_y[2:0];
      end else if (w_start_pend) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign fb_we    = r_fb_we;
  assign fb_addr  = r_fb_addr;
  assign fb_wdata = w_rom_data;
  assign busy     = (r_state != StIdle);
  assign done     = (r_state == StDone);
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_oled_char_draw.sv
// Bench for oled_char_draw: per-cycle comparison against a schedule-based reference model.
module tb_oled_char_draw;

  localparam int MaxCyc = 4096;
  localparam logic [7:0] SubAscii = 8'h20;

  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       draw_start = 1'b0;
  logic [7:0] draw_ascii = 8'h00;
  logic [6:0] draw_x = 7'd0;
  logic [3:0] draw_y = 4'd0;
  logic       ovf_clr = 1'b0;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       busy;
  logic       done;
  logic       ovf;

  always #10 clk_50m = ~clk_50m;

  oled_char_draw #(.SUB_ASCII(SubAscii)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .draw_start (draw_start),
    .draw_ascii (draw_ascii),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .ovf_clr    (ovf_clr),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Per-phase stimulus
  bit st_req[MaxCyc];
  int st_asc[MaxCyc];
  int st_x[MaxCyc];
  int st_y[MaxCyc];
  bit st_clr[MaxCyc];
  int rst_at = -1;

  // Expected per-cycle outputs
  bit ex_we[MaxCyc];
  int ex_addr[MaxCyc];
  int ex_data[MaxCyc];
  bit ex_done[MaxCyc];
  bit ex_busy[MaxCyc];

  int m_last_done = -1;
  int m_pend_s = -1;
  bit m_ovf = 1'b0;
  int m_addr = 0;
  int m_data = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int rom_byte(input int a);
    return (a & 255) ^ (a >> 4);
  endfunction

  function automatic int glyph_code(input int c);
    return (c < 32 || c > 126) ? int'(SubAscii) : c;
  endfunction

  task automatic clear_expect(input int from);
    for (int i = from; i < MaxCyc; i++) begin
      ex_we[i] = 0; ex_addr[i] = 0; ex_data[i] = 0; ex_done[i] = 0; ex_busy[i] = 0;
    end
    m_last_done = -1; m_pend_s = -1; m_ovf = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic clear_phase();
    for (int i = 0; i < MaxCyc; i++) begin
      st_req[i] = 0; st_asc[i] = 0; st_x[i] = 0; st_y[i] = 0; st_clr[i] = 0;
    end
    rst_at = -1;
    clear_expect(0);
  endtask

  task automatic put_req(input int t, input int a, input int x, input int y);
    st_req[t] = 1; st_asc[t] = a; st_x[t] = x; st_y[t] = y;
  endtask

  // Schedule a request made in cycle t: renders start one cycle after acceptance, and a
  // request arriving while busy starts at the current render's done cycle.
  task automatic model_req(input int t, input int a, input int x, input int y, output bit drop);
    int s;
    drop = 0;
    if (t > m_last_done) begin
      if (y > 7) begin
        m_last_done = t + 1;
        ex_busy[t + 1] = 1;
        ex_done[t + 1] = 1;
        return;
      end
      s = t;
    end else begin
      if (y > 7) return;
      if (m_pend_s > t) begin
        drop = 1;
        return;
      end
      s = m_last_done;
      m_pend_s = s;
    end
    m_last_done = s + 18;
    for (int i = s + 1; i <= s + 18; i++) if (i < MaxCyc) ex_busy[i] = 1;
    if (s + 18 < MaxCyc) ex_done[s + 18] = 1;
    for (int k = 0; k < 16; k++) begin
      int col = x + (k % 8);
      int page = y + (k / 8);
      int cy = s + 2 + k;
      if (col <= 127 && page <= 7 && cy < MaxCyc) begin
        ex_we[cy] = 1;
        ex_addr[cy] = page * 128 + col;
        ex_data[cy] = rom_byte((glyph_code(a) - 32) * 16 + k);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    draw_start = 1'b0;
    ovf_clr = 1'b0;
    #1;
    check_eq("rst_we", 32'(fb_we), 32'd0);
    check_eq("rst_addr", 32'(fb_addr), 32'd0);
    check_eq("rst_wdata", 32'(fb_wdata), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk_50m);
    #1;
  endtask

  task automatic run_phase(input int n);
    bit drop;
    for (int c = 0; c < n; c++) begin
      cyc = c;
      drop = 0;
      if (c == rst_at) begin
        rst_n = 1'b0;
        draw_start = 1'b0;
        ovf_clr = 1'b0;
        clear_expect(c);
      end else begin
        rst_n = 1'b1;
        draw_start = st_req[c];
        draw_ascii = st_req[c] ? 8'(st_asc[c]) : 8'($urandom_range(0, 255));
        draw_x = st_req[c] ? 7'(st_x[c]) : 7'($urandom_range(0, 127));
        draw_y = st_req[c] ? 4'(st_y[c]) : 4'($urandom_range(0, 15));
        ovf_clr = st_clr[c];
        if (st_req[c]) model_req(c, st_asc[c], st_x[c], st_y[c], drop);
      end
      @(negedge clk_50m);
      if (ex_we[c]) begin
        m_addr = ex_addr[c];
        m_data = ex_data[c];
      end
      check_eq("fb_we", 32'(fb_we), 32'(ex_we[c]));
      check_eq("fb_addr", 32'(fb_addr), 32'(m_addr));
      check_eq("fb_wdata", 32'(fb_wdata), 32'(m_data));
      check_eq("busy", 32'(busy), 32'(ex_busy[c]));
      check_eq("done", 32'(done), 32'(ex_done[c]));
      check_eq("ovf", 32'(ovf), 32'(m_ovf));
      if (c != rst_at) begin
        if (drop) m_ovf = 1;
        else if (st_clr[c]) m_ovf = 0;
      end
      @(posedge clk_50m);
      #1;
    end
  endtask

  initial begin
    clear_phase();
    do_reset();

    // 'A' at origin
    clear_phase();
    put_req(0, 8'h41, 0, 0);
    run_phase(25);
    do_reset();

    // Bottom-right corner clipping
    clear_phase();
    put_req(0, 8'h5A, 124, 7);
    run_phase(25);
    do_reset();

    // Pending capture and overflow drop
    clear_phase();
    put_req(0, 8'h31, 10, 2);
    put_req(5, 8'h32, 20, 3);
    put_req(6, 8'h33, 30, 4);
    run_phase(45);
    check_eq("ovf_after_drop", 32'(ovf), 32'd1);
    do_reset();

    // Substitution and invalid page
    clear_phase();
    put_req(0, 8'h07, 40, 1);
    put_req(20, 8'h20, 40, 1);
    put_req(40, 8'h41, 5, 9);
    run_phase(50);
    do_reset();

    // Reset mid-render
    clear_phase();
    put_req(0, 8'h48, 3, 3);
    rst_at = 9;
    run_phase(30);
    do_reset();

    // ovf_clr coinciding with a drop, then alone
    clear_phase();
    put_req(0, 8'h61, 0, 0);
    put_req(2, 8'h62, 8, 0);
    put_req(4, 8'h63, 16, 0);
    st_clr[4] = 1;
    st_clr[5] = 1;
    run_phase(25);
    do_reset();

    // Randomized traffic
    clear_phase();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        put_req(c, int'($urandom_range(0, 255)),
                ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 127))
                                            : int'($urandom_range(110, 127)),
                int'($urandom_range(0, 9)));
      end
      st_clr[c] = ($urandom_range(0, 39) == 0);
    end
    rst_at = 1500;
    run_phase(3000);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
